// File: rtl/control_unit_sequencer.sv
// Hardwired T0..T3 controller for the ALU-system datapath: fetch, decode and execute of the 16-bit ISA.
// Optional macro CU_SINGLE_STEP_EN gates each T0 fetch on the Step input.
module control_unit_sequencer #(
   parameter logic [4:0] ALU_ADD    = 5'b10100,
   parameter logic [4:0] ALU_PASSA  = 5'b10000,
   parameter logic [1:0] ARF_PC_SEL = 2'b00,
   parameter logic [1:0] ARF_AR_SEL = 2'b10
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IROut,
   input  logic [3:0]  Flags,
`ifdef CU_SINGLE_STEP_EN
   input  logic        Step,
`endif
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [2:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_ScrSel,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [1:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic        IR_Write,
   output logic        IR_LH,
   output logic        Mem_CS,
   output logic        Mem_WR,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic [1:0]  MuxCSel,
   output logic        MuxDSel,
   output logic        DR_E,
   output logic [1:0]  DR_FunSel,
   output logic [2:0]  T,
   output logic        Halted,
   output logic        Illegal
);

   typedef enum logic [1:0] {S_INIT, S_FETCH, S_EXEC, S_HALT} state_t;

   localparam logic [5:0] OP_BRA = 6'h00, OP_BNE = 6'h01, OP_BEQ = 6'h02, OP_MOVL = 6'h03,
                          OP_INC = 6'h04, OP_ADD = 6'h05, OP_LD  = 6'h06, OP_ST   = 6'h07,
                          OP_HLT = 6'h3F;

   state_t      state;
   logic [1:0]  t;
   logic        step_ok;
   logic [5:0]  op;
   logic [1:0]  rx, ry;
   logic [3:0]  rx_onehot;
   logic        z_flag;
   logic        unused_flags;

   assign op           = IROut[15:10];
   assign rx           = IROut[9:8];
   assign ry           = IROut[7:6];
   assign z_flag       = Flags[3];
   assign unused_flags = ^Flags[2:0];

`ifdef CU_SINGLE_STEP_EN
   assign step_ok = Step;
`else
   assign step_ok = 1'b1;
`endif

   // Register file select is one-hot with R1 in the MSB.
   always_comb begin
      case (rx)
         2'd0:    rx_onehot = 4'b1000;
         2'd1:    rx_onehot = 4'b0100;
         2'd2:    rx_onehot = 4'b0010;
         default: rx_onehot = 4'b0001;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= S_INIT;
         t     <= 2'd0;
      end else begin
         case (state)
            S_INIT: begin
               state <= S_FETCH;
               t     <= 2'd0;
            end
            S_FETCH: begin
               if (t == 2'd0) begin
                  if (step_ok) t <= 2'd1;
               end else begin
                  state <= S_EXEC;
                  t     <= 2'd2;
               end
            end
            S_EXEC: begin
               if (op == OP_LD && t == 2'd2) begin
                  t <= 2'd3;
               end else if (op == OP_HLT) begin
                  state <= S_HALT;
                  t     <= 2'd0;
               end else begin
                  state <= S_FETCH;
                  t     <= 2'd0;
               end
            end
            default: t <= 2'd0;
         endcase
      end
   end

   // State resets asynchronously to INIT, so gate with Reset to keep outputs idle while it is held.
   always_comb begin
      RF_OutASel = 3'b000; RF_OutBSel = 3'b000; RF_FunSel = 3'b000;
      RF_RegSel = 4'b0000; RF_ScrSel = 4'b0000;
      ALU_FunSel = 5'b00000; ALU_WF = 1'b0;
      ARF_OutCSel = 2'b00; ARF_OutDSel = 2'b00; ARF_FunSel = 2'b00; ARF_RegSel = 3'b000;
      IR_Write = 1'b0; IR_LH = 1'b0; Mem_CS = 1'b1; Mem_WR = 1'b0;
      MuxASel = 2'b00; MuxBSel = 2'b00; MuxCSel = 2'b00; MuxDSel = 1'b0;
      DR_E = 1'b0; DR_FunSel = 2'b00;
      Illegal = 1'b0;
      if (Reset) begin
         case (state)
            S_INIT: begin
               ARF_RegSel = 3'b111; ARF_FunSel = 2'b11;
               RF_RegSel  = 4'b1111; RF_FunSel = 3'b011;
            end
            S_FETCH: begin
               if (t != 2'd0 || step_ok) begin
                  ARF_OutDSel = ARF_PC_SEL; Mem_CS = 1'b0;
                  IR_Write = 1'b1; IR_LH = (t == 2'd1);
                  ARF_RegSel = 3'b100; ARF_FunSel = 2'b01;
               end
            end
            S_EXEC: begin
               case (op)
                  OP_BRA, OP_BNE, OP_BEQ: begin
                     if (op == OP_BRA || (op == OP_BNE && !z_flag) || (op == OP_BEQ && z_flag)) begin
                        MuxBSel = 2'b11; ARF_RegSel = 3'b100; ARF_FunSel = 2'b10;
                     end
                  end
                  OP_MOVL: begin
                     MuxASel = 2'b11; RF_RegSel = rx_onehot; RF_FunSel = 3'b010;
                  end
                  OP_INC: begin
                     RF_RegSel = rx_onehot; RF_FunSel = 3'b001;
                  end
                  OP_ADD: begin
                     RF_OutASel = {1'b0, rx}; RF_OutBSel = {1'b0, ry}; MuxDSel = 1'b0;
                     ALU_FunSel = ALU_ADD; ALU_WF = 1'b1;
                     MuxASel = 2'b00; RF_RegSel = rx_onehot; RF_FunSel = 3'b010;
                  end
                  OP_LD: begin
                     if (t == 2'd2) begin
                        ARF_OutDSel = ARF_AR_SEL; Mem_CS = 1'b0;
                        DR_E = 1'b1; DR_FunSel = 2'b01;
                     end else begin
                        MuxASel = 2'b10; RF_RegSel = rx_onehot; RF_FunSel = 3'b010;
                     end
                  end
                  OP_ST: begin
                     RF_OutASel = {1'b0, rx}; MuxDSel = 1'b0; ALU_FunSel = ALU_PASSA;
                     MuxCSel = 2'b00; ARF_OutDSel = ARF_AR_SEL;
                     Mem_CS = 1'b0; Mem_WR = 1'b1;
                  end
                  OP_HLT: ;
                  default: Illegal = 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

   assign T      = {1'b0, t};
   assign Halted = (state == S_HALT);

endmodule
